// File: rtl/loa_accumulator.sv
// Streaming signed accumulator using a lower-part-OR approximate adder.
// Define LOA_ACC_SAT_EN to saturate on overflow instead of wrapping.
module loa_accumulator #(
    parameter int IN_W     = 16,
    parameter int ACC_W    = 24,
    parameter int LOW_BITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_sub,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [15:0]      out_count,
    output logic             out_ovf
);

    localparam int HI_W = ACC_W - LOW_BITS;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] opnd_e;
    logic [ACC_W-1:0] opnd_b;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_upd;
    logic [HI_W-1:0]  hi_sum;
    logic             lo_carry;
    logic             ovf_hit;
    logic             accept;
    logic             drain;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign out_data  = acc;

    // Approximate add: OR in the low part, exact upper part with AND carry-in.
    // The +1 of two's-complement negation is intentionally dropped.
    always_comb begin
        opnd_e   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
        opnd_b   = in_sub ? ~opnd_e : opnd_e;
        lo_carry = acc[LOW_BITS-1] & opnd_b[LOW_BITS-1];
        hi_sum   = acc[ACC_W-1:LOW_BITS]
                 + opnd_b[ACC_W-1:LOW_BITS]
                 + HI_W'(lo_carry);
        sum      = {hi_sum, acc[LOW_BITS-1:0] | opnd_b[LOW_BITS-1:0]};
        ovf_hit  = (acc[ACC_W-1] == opnd_b[ACC_W-1])
                && (sum[ACC_W-1] != acc[ACC_W-1]);
        acc_upd  = sum;
`ifdef LOA_ACC_SAT_EN
        if (ovf_hit) begin
            acc_upd = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    // Next-state decode: last beat freezes, output handshake returns.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ACC:  if (accept && in_last) state_nxt = DONE;
            DONE: if (drain)             state_nxt = ACC;
            default:                     state_nxt = ACC;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nxt;
    end

    // Datapath registers: update on accept, clear on output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (drain) begin
            acc       <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            acc <= acc_upd;
            if (out_count != 16'hFFFF) out_count <= out_count + 16'd1;
            if (ovf_hit) out_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_loa_accumulator.sv
// Directed bench for loa_accumulator with hand-computed expectations.
// Checks OR part, carry path, subtract bias, overflow and backpressure.
module tb_loa_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sub;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [15:0] out_count;
    logic        out_ovf;

    int checks;
    int errors;

    loa_accumulator #(
        .IN_W(16), .ACC_W(24), .LOW_BITS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [15:0] d, input logic s, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_sub   = 1'b0;
    endtask

    task automatic drain_chk(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_vld"}, 32'(out_valid), 32'd0);
        chk({tag, "_clr"}, 32'(out_data), 32'd0);
        chk({tag, "_cnt0"}, 32'(out_count), 32'd0);
        chk({tag, "_ovf0"}, 32'(out_ovf), 32'd0);
    endtask

    initial begin
        logic [23:0] ovf_exp;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sub    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        chk("rst_vld", 32'(out_valid), 32'd0);

        // Reset mid-reduction discards the partial sum
        beat(16'h0003, 1'b0, 1'b0);
        beat(16'h0005, 1'b0, 1'b0);
        chk("mid_data", 32'(out_data), 32'h7);
        chk("mid_cnt", 32'(out_count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_cnt", 32'(out_count), 32'd0);
        chk("arst_ovf", 32'(out_ovf), 32'd0);
        chk("arst_vld", 32'(out_valid), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // OR low part
        beat(16'h0003, 1'b0, 1'b0);
        chk("or_busy", 32'(out_valid), 32'd0);
        beat(16'h0005, 1'b0, 1'b1);
        chk("or_vld", 32'(out_valid), 32'd1);
        chk("or_rdy", 32'(in_ready), 32'd0);
        chk("or_data", 32'(out_data), 32'h000007);
        chk("or_cnt", 32'(out_count), 32'd2);
        chk("or_ovf", 32'(out_ovf), 32'd0);
        drain_chk("or");

        // Carry from AND of low-part MSBs
        beat(16'h0180, 1'b0, 1'b0);
        beat(16'h0080, 1'b0, 1'b1);
        chk("cy_data", 32'(out_data), 32'h000280);
        chk("cy_cnt", 32'(out_count), 32'd2);
        drain_chk("cy");

        // Single-beat subtract shows the -1 bias
        beat(16'h0001, 1'b1, 1'b1);
        chk("sub_vld", 32'(out_valid), 32'd1);
        chk("sub_data", 32'(out_data), 32'hFFFFFE);
        chk("sub_cnt", 32'(out_count), 32'd1);
        chk("sub_ovf", 32'(out_ovf), 32'd0);
        drain_chk("sub");

        // Overflow after 257 beats of 0x7FFF
        for (int i = 0; i < 256; i++) beat(16'h7FFF, 1'b0, 1'b0);
        chk("pre_data", 32'(out_data), 32'h7FFFFF);
        chk("pre_ovf", 32'(out_ovf), 32'd0);
        chk("pre_cnt", 32'(out_count), 32'd256);
        beat(16'h7FFF, 1'b0, 1'b1);
`ifdef LOA_ACC_SAT_EN
        ovf_exp = 24'h7FFFFF;
`else
        ovf_exp = 24'h807FFF;
`endif
        chk("ovf_flag", 32'(out_ovf), 32'd1);
        chk("ovf_cnt", 32'(out_count), 32'd257);
        chk("ovf_data", 32'(out_data), 32'(ovf_exp));

        // Backpressure in DONE with input still offered
        in_valid = 1'b1;
        in_data  = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_vld", 32'(out_valid), 32'd1);
            chk("bp_rdy", 32'(in_ready), 32'd0);
            chk("bp_data", 32'(out_data), 32'(ovf_exp));
            chk("bp_cnt", 32'(out_count), 32'd257);
            chk("bp_ovf", 32'(out_ovf), 32'd1);
        end
        in_valid = 1'b0;
        drain_chk("bp");

        // A fresh reduction after clear starts from zero
        beat(16'h0010, 1'b0, 1'b1);
        chk("post_data", 32'(out_data), 32'h000010);
        chk("post_cnt", 32'(out_count), 32'd1);
        drain_chk("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
